// File: rtl/lacnch_pkg.sv
// Shared constants for the nibble demux: FSM state encoding, channel count, default nibble width.
package lacnch_pkg;
  localparam int NUM_CH = 16;
  localparam int NIB_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LOAD   = 2'b01,
    ST_COMMIT = 2'b10
  } state_t;
endpackage

// File: rtl/dec4_16_we.sv
// Combinational 4-to-16 one-hot write-enable decoder; all zeros when en_i is low.
module dec4_16_we
  import lacnch_pkg::*;
(
  input  logic [3:0]        addr_i,
  input  logic              en_i,
  output logic [NUM_CH-1:0] we_o
);
  always_comb begin
    we_o = '0;
    if (en_i) we_o[addr_i] = 1'b1;
  end
endmodule

// File: rtl/demux4bit_16_frame.sv
// Distributes a nibble stream into 16 registered channels, either one addressed nibble at a time
// or as a 16-nibble frame staged in a shadow bank and committed atomically one cycle after the last beat.
module demux4bit_16_frame
  import lacnch_pkg::*;
#(
  parameter int                 DATA_W  = NIB_W,
  parameter logic [DATA_W-1:0]  RST_VAL = '0
)
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [DATA_W-1:0] Din,
  input  logic              Dvalid,
  input  logic              Start,
  input  logic              S0,
  input  logic              S1,
  input  logic              S2,
  input  logic              S3,
  output logic              Dready,
  output logic              Busy,
  output logic              Frame_done,
  output logic [DATA_W-1:0] Q0,
  output logic [DATA_W-1:0] Q1,
  output logic [DATA_W-1:0] Q2,
  output logic [DATA_W-1:0] Q3,
  output logic [DATA_W-1:0] Q4,
  output logic [DATA_W-1:0] Q5,
  output logic [DATA_W-1:0] Q6,
  output logic [DATA_W-1:0] Q7,
  output logic [DATA_W-1:0] Q8,
  output logic [DATA_W-1:0] Q9,
  output logic [DATA_W-1:0] Q10,
  output logic [DATA_W-1:0] Q11,
  output logic [DATA_W-1:0] Q12,
  output logic [DATA_W-1:0] Q13,
  output logic [DATA_W-1:0] Q14,
  output logic [DATA_W-1:0] Q15
);
  state_t                         state_q, state_d;
  logic [3:0]                     cnt_q, cnt_d;
  logic                           frame_done_q, frame_done_d;
  logic [NUM_CH-1:0][DATA_W-1:0]  q_q, q_d;
  logic [NUM_CH-1:0][DATA_W-1:0]  sh_q, sh_d;

  logic              accept;
  logic              q_we_en, sh_we_en, commit;
  logic [3:0]        sh_idx;
  logic [NUM_CH-1:0] q_we, sh_we;

  assign Dready = RST_N && ((state_q == ST_IDLE) || (state_q == ST_LOAD));
  assign Busy   = RST_N && ((state_q == ST_LOAD) || (state_q == ST_COMMIT));
  assign accept = Dvalid && Dready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    q_we_en      = 1'b0;
    sh_we_en     = 1'b0;
    sh_idx       = cnt_q;
    commit       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (Start) begin
            sh_we_en = 1'b1;
            sh_idx   = 4'd0;
            cnt_d    = 4'd1;
            state_d  = ST_LOAD;
          end else begin
            q_we_en  = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (accept) begin
          sh_we_en = 1'b1;
          // A fresh Start restarts the frame even if the previous one was one beat from done.
          if (Start) begin
            sh_idx = 4'd0;
            cnt_d  = 4'd1;
          end else begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) state_d = ST_COMMIT;
          end
        end
      end
      ST_COMMIT: begin
        commit  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    frame_done_d = commit;
  end

  dec4_16_we u_dec_q (
    .addr_i ({S3, S2, S1, S0}),
    .en_i   (q_we_en),
    .we_o   (q_we)
  );

  dec4_16_we u_dec_sh (
    .addr_i (sh_idx),
    .en_i   (sh_we_en),
    .we_o   (sh_we)
  );

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      q_d[i]  = commit ? sh_q[i] : (q_we[i] ? Din : q_q[i]);
      sh_d[i] = sh_we[i] ? Din : sh_q[i];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        q_q[i]  <= RST_VAL;
        sh_q[i] <= RST_VAL;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
      q_q          <= q_d;
      sh_q         <= sh_d;
    end
  end

  assign Frame_done = frame_done_q;

  assign Q0  = q_q[0];
  assign Q1  = q_q[1];
  assign Q2  = q_q[2];
  assign Q3  = q_q[3];
  assign Q4  = q_q[4];
  assign Q5  = q_q[5];
  assign Q6  = q_q[6];
  assign Q7  = q_q[7];
  assign Q8  = q_q[8];
  assign Q9  = q_q[9];
  assign Q10 = q_q[10];
  assign Q11 = q_q[11];
  assign Q12 = q_q[12];
  assign Q13 = q_q[13];
  assign Q14 = q_q[14];
  assign Q15 = q_q[15];
endmodule

// File: tb/tb_demux4bit_16_frame.sv
// Bench for demux4bit_16_frame: directed scenarios plus random traffic against a queue-based frame model.
module tb_demux4bit_16_frame;
  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [3:0] Din = 4'd0;
  logic       Dvalid = 1'b0;
  logic       Start = 1'b0;
  logic [3:0] sel = 4'd0;
  logic       Dready, Busy, Frame_done;
  logic [3:0] Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7, Q8, Q9, Q10, Q11, Q12, Q13, Q14, Q15;
  logic [63:0] dut_qvec;

  int checks = 0;
  int errors = 0;

  logic [3:0] mdl_q [16];
  logic [3:0] mdl_buf [$];
  bit         mdl_in_frame = 1'b0;
  bit         mdl_pend = 1'b0;
  bit         mdl_fd = 1'b0;

  always #5 CLK = ~CLK;

  demux4bit_16_frame dut (
    .CLK(CLK), .RST_N(RST_N), .Din(Din), .Dvalid(Dvalid), .Start(Start),
    .S0(sel[0]), .S1(sel[1]), .S2(sel[2]), .S3(sel[3]),
    .Dready(Dready), .Busy(Busy), .Frame_done(Frame_done),
    .Q0(Q0), .Q1(Q1), .Q2(Q2), .Q3(Q3), .Q4(Q4), .Q5(Q5), .Q6(Q6), .Q7(Q7),
    .Q8(Q8), .Q9(Q9), .Q10(Q10), .Q11(Q11), .Q12(Q12), .Q13(Q13), .Q14(Q14), .Q15(Q15)
  );

  assign dut_qvec = {Q15, Q14, Q13, Q12, Q11, Q10, Q9, Q8, Q7, Q6, Q5, Q4, Q3, Q2, Q1, Q0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mdl_qvec();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[i*4 +: 4] = mdl_q[i];
    return v;
  endfunction

  // Frame model: nibbles collect in a queue; the 16th one arms a commit that lands one edge later.
  task automatic model_edge();
    if (!RST_N) begin
      for (int i = 0; i < 16; i++) mdl_q[i] = 4'd0;
      mdl_buf.delete();
      mdl_in_frame = 1'b0;
      mdl_pend = 1'b0;
      mdl_fd = 1'b0;
    end else begin
      mdl_fd = 1'b0;
      if (mdl_pend) begin
        for (int i = 0; i < 16; i++) mdl_q[i] = mdl_buf[i];
        mdl_buf.delete();
        mdl_pend = 1'b0;
        mdl_in_frame = 1'b0;
        mdl_fd = 1'b1;
      end else if (Dvalid) begin
        if (Start) begin
          mdl_buf.delete();
          mdl_buf.push_back(Din);
          mdl_in_frame = 1'b1;
        end else if (mdl_in_frame) begin
          mdl_buf.push_back(Din);
          if (mdl_buf.size() == 16) mdl_pend = 1'b1;
        end else begin
          mdl_q[sel] = Din;
        end
      end
    end
  endtask

  task automatic cyc(input string tag);
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    chk({tag, "_q"}, dut_qvec, mdl_qvec());
    chk({tag, "_dready"}, 64'(Dready), 64'(RST_N && !mdl_pend));
    chk({tag, "_busy"}, 64'(Busy), 64'(RST_N && mdl_in_frame));
    chk({tag, "_fdone"}, 64'(Frame_done), 64'(mdl_fd));
  endtask

  task automatic drive(input logic v, input logic st, input logic [3:0] d, input logic [3:0] s,
                       input string tag);
    Dvalid = v;
    Start  = st;
    Din    = d;
    sel    = s;
    cyc(tag);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mdl_q[i] = 4'd0;

    // Reset held for two edges, then released.
    cyc("rst0");
    cyc("rst1");
    RST_N = 1'b1;
    #1;
    chk("rst_rel_dready", 64'(Dready), 64'd1);
    chk("rst_rel_busy", 64'(Busy), 64'd0);
    chk("rst_rel_q", dut_qvec, 64'd0);
    drive(1'b0, 1'b0, 4'd0, 4'd0, "idle");

    // Addressed write to channel 5.
    drive(1'b1, 1'b0, 4'hA, 4'b0101, "addr");
    chk("addr_q5", dut_qvec, 64'h0000_0000_00A0_0000);
    drive(1'b0, 1'b0, 4'd0, 4'd0, "idle");

    // Full back-to-back frame 0..F, with a beat offered during COMMIT.
    drive(1'b1, 1'b1, 4'd0, 4'd0, "frm");
    for (int k = 1; k < 16; k++) drive(1'b1, 1'b0, 4'(k), 4'd0, "frm");
    chk("frm_commit_dready", 64'(Dready), 64'd0);
    chk("frm_commit_q_hold", dut_qvec, 64'h0000_0000_00A0_0000);
    drive(1'b1, 1'b0, 4'hE, 4'd0, "frm_cmt");
    chk("frm_fdone", 64'(Frame_done), 64'd1);
    chk("frm_q", dut_qvec, 64'hFEDC_BA98_7654_3210);
    drive(1'b0, 1'b0, 4'd0, 4'd0, "frm_after");
    chk("frm_fdone_clr", 64'(Frame_done), 64'd0);
    chk("frm_q0_kept", 64'(Q0), 64'd0);

    // Gapped frame abandoned by a restart.
    drive(1'b1, 1'b1, 4'd7, 4'd0, "gap");
    for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, 4'd7, 4'd0, "gap");
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 4'd7, 4'd0, "gap_hold");
    drive(1'b1, 1'b1, 4'd3, 4'd0, "rst_frm");
    for (int k = 0; k < 15; k++) drive(1'b1, 1'b0, 4'hC, 4'd0, "rst_frm");
    drive(1'b0, 1'b0, 4'd0, 4'd0, "rst_frm_cmt");
    chk("restart_q", dut_qvec, 64'hCCCC_CCCC_CCCC_CCC3);

    // Reset in the middle of a frame.
    drive(1'b1, 1'b1, 4'd5, 4'd0, "mid");
    for (int k = 0; k < 7; k++) drive(1'b1, 1'b0, 4'd5, 4'd0, "mid");
    RST_N = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 4'd0, "mid_rst");
    RST_N = 1'b1;
    #1;
    chk("mid_rst_q", dut_qvec, 64'd0);
    chk("mid_rst_busy", 64'(Busy), 64'd0);
    drive(1'b1, 1'b0, 4'd9, 4'hF, "post_rst");
    chk("post_rst_q15", 64'(Q15), 64'd9);
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 4'd0, 4'd0, "post_rst_idle");

    // Random traffic with occasional starts and resets.
    for (int n = 0; n < 2000; n++) begin
      RST_N = ($urandom_range(0, 249) != 0);
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 24) == 0, 4'($urandom), 4'($urandom), "rnd");
    end
    RST_N = 1'b1;
    for (int k = 0; k < 20; k++) drive(1'b0, 1'b0, 4'd0, 4'd0, "drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/demux4bit_16_frame.md
Name: demux4bit_16_frame

Overview:
- Write-side counterpart of the 16:1 4-bit nibble selector used on the LaunchPad pad/LED grid.
- Accepts 4-bit nibbles from a single input stream and distributes them into 16 registered 4-bit channels Q0..Q15. The selector side then reads those channels with S0..S3.
- Two write modes:
  - Addressed: single nibble written to the channel picked by S0..S3.
  - Frame: 16 consecutive nibbles buffered in a shadow bank, then committed to all channels together, so readers never see a partly updated frame.

Parameters:
- DATA_W, 4, nibble width; every Q channel and Din have this width.
- RST_VAL, 4'h0, value loaded into every Q and shadow entry on reset.

Ports:
- CLK  input  1  single clock, rising edge.
- RST_N  input  1  reset, synchronous, active-low.
- Din  input  DATA_W  write data.
- Dvalid  input  1  Din valid; a beat is accepted only when Dvalid=1 and Dready=1 on the same edge.
- Start  input  1  qualified by an accepted beat; marks that beat as the first nibble (index 0) of a frame.
- S0,S1,S2,S3  input  1 each  channel address for addressed writes; S3 is the MSB, address = {S3,S2,S1,S0}.
- Dready  output  1  block can accept a beat.
- Busy  output  1  a frame is in progress (state LOAD or COMMIT).
- Frame_done  output  1  one-cycle pulse marking the frame commit.
- Q0..Q15  output  DATA_W each  registered channel outputs.

Behaviour:
- Reset:
  - Synchronous, active-low, one clock, one clock domain; RST_N=0 sampled on a CLK edge resets the block.
  - On that edge: Q0..Q15 = RST_VAL, shadow[0..15] = RST_VAL, cnt = 0, state = IDLE, Frame_done = 0.
  - Dready = 0 and Busy = 0 while RST_N=0.
  - Reset overrides every other input, including mid-frame; partial shadow contents are discarded.
- Dready = 1 in IDLE and LOAD; 0 in COMMIT and during reset.
- Busy = 1 in LOAD and COMMIT.
- IDLE:
  - Accepted beat with Start=0: Q[{S3..S0}] <= Din at that edge. Visible one cycle after acceptance; other channels unchanged.
  - Accepted beat with Start=1: shadow[0] <= Din, cnt <= 1, go to LOAD. Q is not modified.
- LOAD:
  - Accepted beat with Start=0: shadow[cnt] <= Din, cnt <= cnt+1.
  - When the beat at cnt=15 is accepted, go to COMMIT (cnt wraps to 0).
  - Accepted beat with Start=1: restart. shadow[0] <= Din, cnt <= 1, stay in LOAD. Earlier shadow entries are overwritten as the new frame fills them.
  - S0..S3 are ignored in LOAD; addressed writes are not possible mid-frame.
  - Dvalid=0 cycles (gaps) hold cnt; there is no timeout.
- COMMIT (single cycle):
  - Q0..Q15 <= shadow[0..15] on the edge that leaves COMMIT; next state IDLE.
  - Frame_done is registered: it is 1 for exactly the cycle in which the new Q values first appear, then 0.
  - Dvalid is ignored (Dready=0).
- Frame latency: the 16th accepted beat at edge N gives new Q values and Frame_done=1 in the cycle after edge N+1. Minimum frame period is 17 cycles.
- Widths and counter:
  - cnt is 4 bits; no arithmetic on data.
  - Shadow indexing uses cnt directly; the shadow bank uses no reset other than RST_VAL.
- State encoding: 2 bits, IDLE=00, LOAD=01, COMMIT=10. Illegal value 11 returns to IDLE on the next edge with Q unchanged.

Decomposition:
- Shared package lacnch_pkg holds:
  - state constants ST_IDLE, ST_LOAD, ST_COMMIT;
  - NUM_CH = 16;
  - default nibble width 4.
- One sub-module: dec4_16_we. This is a combinational 4-to-16 one-hot write-enable decoder. Inputs: 4-bit address and enable; output: 16-bit one-hot.
  - Instantiated twice: once for the addressed Q write, once for the shadow write (addressed by cnt).

Test Plan:
- Reset: hold RST_N=0 for 2 cycles, then release -> all Q = 0, Dready = 1 on the first cycle after release, Busy = 0, Frame_done = 0.
- Addressed write: Din=4'hA, S={S3..S0}=4'b0101, Dvalid pulse in IDLE -> Q5 = A one cycle later; all other Q stay 0.
- Full frame: Start with Din=0, then Din=1..15 back-to-back -> Q unchanged during LOAD; Q0..Q15 = 0..F and Frame_done=1 for one cycle, 2 cycles after the last beat; Dready = 0 during COMMIT.
- Gapped frame with restart: send 5 beats (values 7), Dvalid low for 3 cycles, then Start with Din=3 and 15 beats of C -> committed Q0 = 3, Q1..Q15 = C; cnt holds during the gap.
- Reset mid-frame: after 8 frame beats, RST_N=0 for one edge -> Q all 0, state IDLE, no Frame_done; a following addressed write to S=4'hF with Din=9 -> Q15 = 9.
- Dvalid during COMMIT: drive Dvalid=1 with Din=E, S=0 in the COMMIT cycle -> beat not accepted; Q0 keeps its committed value.
